// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Select codes match the shared-bus datapath mux wiring.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } statetype_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU operation decode from FSM aluop and instruction fields.
// Purely combinational; no state.
module aludec
   import riscv_mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only means sub for register-register ops; addi ignores it
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM sequencing the RV32I multicycle datapath; all outputs combinational.
// Write enables are held low while reset_n is asserted.
module mc_controller
   import riscv_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic [1:0] immsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] resultsrc,
   output logic       adrsrc,
   output logic [2:0] alucontrol,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       regwrite,
   output logic       memwrite
);

   statetype_t r_state;
   statetype_t w_next;
   logic [1:0] w_aluop;
   logic       w_branch;
   logic       w_pcupdate;
   logic       w_irwrite;
   logic       w_regwrite;
   logic       w_memwrite;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_FETCH;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      alusrca    = SRCA_PC;
      alusrcb    = SRCB_REG;
      resultsrc  = RES_ALUOUT;
      adrsrc     = 1'b0;
      w_aluop    = ALUOP_ADD;
      w_branch   = 1'b0;
      w_pcupdate = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      case (r_state)
         S_FETCH: begin
            alusrcb    = SRCB_FOUR;
            resultsrc  = RES_ALURESULT;
            w_irwrite  = 1'b1;
            w_pcupdate = 1'b1;
         end
         S_DECODE: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
         end
         S_MEMADR: begin
            alusrca = SRCA_REG;
            alusrcb = SRCB_IMM;
         end
         S_MEMREAD:  adrsrc = 1'b1;
         S_MEMWB: begin
            resultsrc  = RES_DATA;
            w_regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            adrsrc     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTER: begin
            alusrca = SRCA_REG;
            w_aluop = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            alusrca = SRCA_REG;
            alusrcb = SRCB_IMM;
            w_aluop = ALUOP_FUNCT;
         end
         S_ALUWB:    w_regwrite = 1'b1;
         S_BEQ: begin
            alusrca  = SRCA_REG;
            w_aluop  = ALUOP_SUB;
            w_branch = 1'b1;
         end
         S_JAL: begin
            alusrca    = SRCA_OLDPC;
            alusrcb    = SRCB_FOUR;
            w_pcupdate = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (op)
         OP_LW, OP_I: immsrc = IMM_I;
         OP_SW:       immsrc = IMM_S;
         OP_BEQ:      immsrc = IMM_B;
         OP_JAL:      immsrc = IMM_J;
         default:     immsrc = IMM_I;
      endcase
   end

   aludec u_aludec (
      .aluop      (w_aluop),
      .op5        (op[5]),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .alucontrol (alucontrol)
   );

   // Gating on reset_n keeps an aborted instruction from committing anything
   assign irwrite  = w_irwrite & reset_n;
   assign pcwrite  = (w_pcupdate | (w_branch & zero)) & reset_n;
   assign regwrite = w_regwrite & reset_n;
   assign memwrite = w_memwrite & reset_n;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle output vectors for each instruction class.
module tb_mc_controller;

   logic       clk;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
   logic       adrsrc;
   logic [2:0] alucontrol;
   logic       irwrite, pcwrite, regwrite, memwrite;
   logic [15:0] obs;

   int n_cmp = 0;
   int n_err = 0;

   mc_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .immsrc     (immsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .resultsrc  (resultsrc),
      .adrsrc     (adrsrc),
      .alucontrol (alucontrol),
      .irwrite    (irwrite),
      .pcwrite    (pcwrite),
      .regwrite   (regwrite),
      .memwrite   (memwrite)
   );

   // {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol, irwrite, pcwrite, regwrite, memwrite}
   assign obs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                 irwrite, pcwrite, regwrite, memwrite};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      logic [15:0] exp_rst;
      exp_rst = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b0000};
      reset_n = 1'b0; op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      #2;
      n_cmp++;
      if (obs !== exp_rst) begin
         n_err++; $display("FAIL reset_initial: got %b expected %b", obs, exp_rst);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== exp_rst) begin
         n_err++; $display("FAIL reset_held: got %b expected %b", obs, exp_rst);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_lw();
      logic [15:0] exp_v [6];
      exp_v = '{{2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100},
                {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000},
                {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 4'b0010},
                {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100}};
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin @(posedge clk); end
         #1;
         n_cmp++;
         if (obs !== exp_v[c]) begin
            n_err++; $display("FAIL lw cycle %0d: got %b expected %b", c + 1, obs, exp_v[c]);
         end
      end
   endtask

   task automatic test_sw();
      logic [15:0] exp_v [5];
      exp_v = '{{2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100},
                {2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0001},
                {2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100}};
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin @(posedge clk); end
         #1;
         n_cmp++;
         if (obs !== exp_v[c]) begin
            n_err++; $display("FAIL sw cycle %0d: got %b expected %b", c + 1, obs, exp_v[c]);
         end
      end
   endtask

   task automatic test_beq(input logic z);
      logic [15:0] exp_v [4];
      exp_v = '{{2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100},
                {2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, z, 2'b00},
                {2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100}};
      op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin @(posedge clk); end
         #1;
         n_cmp++;
         if (obs !== exp_v[c]) begin
            n_err++; $display("FAIL beq zero=%0b cycle %0d: got %b expected %b", z, c + 1, obs, exp_v[c]);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_alu_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [15:0] exp_exec);
      logic [15:0] exp_v [5];
      exp_v = '{{2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100},
                {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                exp_exec,
                {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0010},
                {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100}};
      op = opc; funct3 = f3; funct7b5 = f7; zero = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin @(posedge clk); end
         #1;
         n_cmp++;
         if (obs !== exp_v[c]) begin
            n_err++; $display("FAIL alu op=%b f3=%b f7b5=%0b cycle %0d: got %b expected %b",
                              opc, f3, f7, c + 1, obs, exp_v[c]);
         end
      end
   endtask

   task automatic test_aludec();
      // R-type: alusrca 10, alusrcb 00; I-type: alusrcb 01
      test_alu_exec(7'b0110011, 3'b000, 1'b1, {2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 4'b0000});
      test_alu_exec(7'b0110011, 3'b000, 1'b0, {2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0000});
      test_alu_exec(7'b0010011, 3'b000, 1'b1, {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000});
      test_alu_exec(7'b0110011, 3'b111, 1'b0, {2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b010, 4'b0000});
      test_alu_exec(7'b0010011, 3'b110, 1'b0, {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b011, 4'b0000});
      test_alu_exec(7'b0110011, 3'b010, 1'b0, {2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b101, 4'b0000});
      test_alu_exec(7'b0110011, 3'b001, 1'b1, {2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0000});
   endtask

   task automatic test_jal();
      logic [15:0] exp_v [5];
      exp_v = '{{2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100},
                {2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 4'b0100},
                {2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0010},
                {2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100}};
      op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin @(posedge clk); end
         #1;
         n_cmp++;
         if (obs !== exp_v[c]) begin
            n_err++; $display("FAIL jal cycle %0d: got %b expected %b", c + 1, obs, exp_v[c]);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_illegal();
      logic [15:0] exp_v [3];
      exp_v = '{{2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100},
                {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000},
                {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100}};
      op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin @(posedge clk); end
         #1;
         n_cmp++;
         if (obs !== exp_v[c]) begin
            n_err++; $display("FAIL illegal cycle %0d: got %b expected %b", c + 1, obs, exp_v[c]);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_reset_midinstr();
      logic [15:0] exp_memread, exp_rst, exp_fetch, exp_decode;
      exp_memread = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000};
      exp_rst     = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b0000};
      exp_fetch   = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b1100};
      exp_decode  = {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000};
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== exp_memread) begin
         n_err++; $display("FAIL rst_mid memread: got %b expected %b", obs, exp_memread);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== exp_rst) begin
         n_err++; $display("FAIL rst_mid immediate: got %b expected %b", obs, exp_rst);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== exp_rst) begin
         n_err++; $display("FAIL rst_mid held: got %b expected %b", obs, exp_rst);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (obs !== exp_fetch) begin
         n_err++; $display("FAIL rst_mid fetch: got %b expected %b", obs, exp_fetch);
      end
      op = 7'b0000000;
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== exp_decode) begin
         n_err++; $display("FAIL rst_mid decode: got %b expected %b", obs, exp_decode);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== exp_fetch) begin
         n_err++; $display("FAIL rst_mid refetch: got %b expected %b", obs, exp_fetch);
      end
   endtask

   task automatic test_back_to_back();
      test_sw();
      test_lw();
      test_beq(1'b1);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_beq(1'b1);
      test_beq(1'b0);
      test_aludec();
      test_jal();
      test_illegal();
      test_back_to_back();
      test_reset_midinstr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
